// File: rtl/sm_test_mem_initiator_pkg.sv
// Shared memory-message encodings, message width helpers and initiator state type.
package sm_test_mem_initiator_pkg;

    localparam logic [2:0] c_mem_type_read  = 3'd0;
    localparam logic [2:0] c_mem_type_write = 3'd1;

    // Request: type[3] opaque[o] addr[a] len[2] data[d]
    function automatic int req_nbits(input int o, input int a, input int d);
        return 3 + o + a + 2 + d;
    endfunction

    // Response: type[3] opaque[o] test[2] len[2] data[d]
    function automatic int resp_nbits(input int o, input int d);
        return 3 + o + 2 + 2 + d;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/sm_test_mem_initiator_if.sv
// Single-port test-memory request/response channel; master is the requester side.
interface sm_test_mem_initiator_if #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
);
    localparam int c_req_nbits  = sm_test_mem_initiator_pkg::req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
    localparam int c_resp_nbits = sm_test_mem_initiator_pkg::resp_nbits(p_opaque_nbits, p_data_nbits);

    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [c_req_nbits-1:0]  memreq_msg;
    logic                    memresp_val;
    logic                    memresp_rdy;
    logic [c_resp_nbits-1:0] memresp_msg;

    modport master (
        output memreq_val, memreq_msg, memresp_rdy,
        input  memreq_rdy, memresp_val, memresp_msg
    );

    modport slave (
        input  memreq_val, memreq_msg, memresp_rdy,
        output memreq_rdy, memresp_val, memresp_msg
    );

endinterface

// File: rtl/sm_test_mem_initiator_msg.sv
// Packs request fields into a memory request message and splits a response message into fields.
// Latency: purely combinational. Backpressure: none; message is all-zero whenever req_val is low.
// Test bits of the response are not meaningful to the initiator and are left unread.
module sm_test_mem_initiator_msg
    import sm_test_mem_initiator_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
) (
    input  logic                                                  req_val,
    input  logic                                                  req_write,
    input  logic [p_opaque_nbits-1:0]                             req_opaque,
    input  logic [p_addr_nbits-1:0]                               req_addr,
    input  logic [p_data_nbits-1:0]                               req_data,
    output logic [req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] req_msg,
    input  logic [resp_nbits(p_opaque_nbits, p_data_nbits)-1:0]   resp_msg,
    output logic [2:0]                                            resp_type,
    output logic [p_opaque_nbits-1:0]                             resp_opaque,
    output logic [1:0]                                            resp_len,
    output logic [p_data_nbits-1:0]                               resp_data
);
    localparam int d = p_data_nbits;
    localparam int o = p_opaque_nbits;

    logic [2:0]   req_type;
    logic [d-1:0] req_data_f;

    assign req_type   = req_write ? c_mem_type_write : c_mem_type_read;
    assign req_data_f = req_write ? req_data : '0;
    assign req_msg    = req_val ? {req_type, req_opaque, req_addr, 2'b00, req_data_f} : '0;

    assign resp_data   = resp_msg[d-1:0];
    assign resp_len    = resp_msg[d+1:d];
    assign resp_opaque = resp_msg[d+4+o-1:d+4];
    assign resp_type   = resp_msg[d+o+6:d+o+4];

endmodule

// File: rtl/sm_test_mem_initiator.sv
// Writes seed+i over a word range, drains, reads it back and counts response mismatches.
// Latency: first request the cycle after go; done the cycle after the last read response handshake.
// Backpressure: requests stall on memreq_rdy or the in-flight limit; responses always accepted out of reset.
module sm_test_mem_initiator
    import sm_test_mem_initiator_pkg::*;
#(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [p_addr_nbits-1:0]  base_addr,
    input  logic [15:0]              num_words,
    input  logic [p_data_nbits-1:0]  seed,
    sm_test_mem_initiator_if.master  mem,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [15:0]              err_count
);
    localparam int c_out_nbits  = $clog2(p_max_outstanding + 1);
    localparam int c_req_nbits  = req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
    localparam int c_resp_nbits = resp_nbits(p_opaque_nbits, p_data_nbits);
    localparam logic [c_out_nbits-1:0]  c_max_out  = c_out_nbits'(p_max_outstanding);
    localparam logic [c_out_nbits-1:0]  c_out_one  = c_out_nbits'(1);
    localparam logic [p_addr_nbits-1:0] c_stride   = p_addr_nbits'(p_data_nbits / 8);
    localparam logic [p_data_nbits-1:0] c_data_one = p_data_nbits'(1);

    state_t                    state;
    logic [15:0]               nwords, idx, ridx;
    logic [c_out_nbits-1:0]    outstanding, out_next;
    logic [p_addr_nbits-1:0]   base_q, addr;
    logic [p_data_nbits-1:0]   seed_q, wdata, exp_data;

    logic                      req_hs, resp_hs, resp_ok, resp_stray, mismatch, err_inc;
    logic                      read_phase, last_req;
    logic [c_req_nbits-1:0]    req_msg;
    logic [c_resp_nbits-1:0]   resp_msg;
    logic [2:0]                resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [1:0]                resp_len;
    logic [p_data_nbits-1:0]   resp_data;

    assign busy       = (state == S_WRITE) || (state == S_WDRAIN) || (state == S_READ) || (state == S_RDRAIN);
    assign done       = (state == S_DONE);
    assign error      = (err_count != 16'd0);
    assign read_phase = (state == S_READ) || (state == S_RDRAIN);

    assign mem.memreq_val  = ((state == S_WRITE) || (state == S_READ)) && (outstanding < c_max_out);
    assign mem.memreq_msg  = req_msg;
    assign mem.memresp_rdy = reset;
    assign resp_msg        = mem.memresp_msg;

    assign req_hs     = mem.memreq_val && mem.memreq_rdy;
    assign resp_hs    = mem.memresp_val && mem.memresp_rdy;
    // Anything outside an active phase, or with nothing in flight, is unsolicited.
    assign resp_ok    = resp_hs && busy && (outstanding != '0);
    assign resp_stray = resp_hs && !resp_ok;
    assign last_req   = req_hs && (idx == nwords - 16'd1);

    assign mismatch = (resp_type != (read_phase ? c_mem_type_read : c_mem_type_write))
                   || (resp_opaque != p_opaque_nbits'(ridx))
                   || (resp_len != 2'd0)
                   || (read_phase && (resp_data != exp_data));
    assign err_inc  = resp_stray || (resp_ok && mismatch);

    sm_test_mem_initiator_msg #(
        .p_opaque_nbits (p_opaque_nbits),
        .p_addr_nbits   (p_addr_nbits),
        .p_data_nbits   (p_data_nbits)
    ) u_msg (
        .req_val     (mem.memreq_val),
        .req_write   (state == S_WRITE),
        .req_opaque  (p_opaque_nbits'(idx)),
        .req_addr    (addr),
        .req_data    (wdata),
        .req_msg     (req_msg),
        .resp_msg    (resp_msg),
        .resp_type   (resp_type),
        .resp_opaque (resp_opaque),
        .resp_len    (resp_len),
        .resp_data   (resp_data)
    );

    always_comb begin
        out_next = outstanding;
        if (req_hs && !resp_ok)
            out_next = outstanding + c_out_one;
        else if (!req_hs && resp_ok)
            out_next = outstanding - c_out_one;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            nwords      <= '0;
            idx         <= '0;
            ridx        <= '0;
            outstanding <= '0;
            base_q      <= '0;
            addr        <= '0;
            seed_q      <= '0;
            wdata       <= '0;
            exp_data    <= '0;
            err_count   <= '0;
        end else begin
            outstanding <= out_next;
            if (err_inc && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
            if (resp_ok) begin
                ridx     <= ridx + 16'd1;
                exp_data <= exp_data + c_data_one;
            end
            if (req_hs) begin
                idx   <= idx + 16'd1;
                addr  <= addr + c_stride;
                wdata <= wdata + c_data_one;
            end
            case (state)
                S_IDLE, S_DONE: if (go) begin
                    nwords    <= num_words;
                    base_q    <= base_addr;
                    seed_q    <= seed;
                    idx       <= '0;
                    ridx      <= '0;
                    addr      <= base_addr;
                    wdata     <= seed;
                    exp_data  <= seed;
                    err_count <= {15'd0, err_inc};
                    state     <= (num_words == 16'd0) ? S_DONE : S_WRITE;
                end
                S_WRITE: if (last_req) begin
                    state <= S_WDRAIN;
                    idx   <= '0;
                    addr  <= base_q;
                end
                // Leave a drain on the very handshake that empties the pipe so done is one cycle late at most.
                S_WDRAIN: if (out_next == '0) begin
                    state    <= S_READ;
                    ridx     <= '0;
                    exp_data <= seed_q;
                end
                S_READ:   if (last_req) state <= S_RDRAIN;
                S_RDRAIN: if (out_next == '0) state <= S_DONE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_test_mem_initiator.sv
// Random-delay in-order test memory plus request-sequence and error-count reference model.
module tb_sm_test_mem_initiator;
    localparam int O      = 8;
    localparam int A      = 32;
    localparam int D      = 32;
    localparam int MAXO   = 4;
    localparam int REQ_W  = 3 + O + A + 2 + D;
    localparam int RESP_W = 3 + O + 2 + 2 + D;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic        busy, done, error;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    sm_test_mem_initiator_if #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D)) mem_if ();

    sm_test_mem_initiator #(
        .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D), .p_max_outstanding(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .base_addr(base_addr), .num_words(num_words),
        .seed(seed), .mem(mem_if), .busy(busy), .done(done), .error(error), .err_count(err_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [RESP_W-1:0] msg;
        int                rdy_cyc;
        bit                is_read;
    } resp_t;

    resp_t       resp_q[$];
    resp_t       rsp;
    logic [31:0] mem_arr [logic [31:0]];
    int          cyc;

    int          max_dly = 0;
    bit          rand_rdy = 0;
    int          stall_cnt = 0;
    bit          hold_reads = 0;
    bit          limit_reads = 0;
    int          reads_acc = 0;
    bit          corrupt_en = 0;
    logic [31:0] corrupt_addr = '0;

    logic [31:0] exp_base = '0, exp_seed = '0;
    int          exp_n = 0;
    int          req_cnt = 0, resp_cnt = 0, mon_out = 0, mon_max = 0, val_cycles = 0;
    bit          lat_chk = 0, done_next = 0, stall_have = 0;
    logic [REQ_W-1:0] stall_msg, m;
    logic [2:0]  r_type;
    logic [7:0]  r_op;
    logic [31:0] r_addr, r_data, rd;

    // Request k of a run: k < n are writes of seed+i, the rest reads; address stride 4 bytes.
    function automatic logic [REQ_W-1:0] exp_req(input int k);
        bit          wr;
        int          i;
        logic [31:0] a, d;
        wr = (k < exp_n);
        i  = wr ? k : k - exp_n;
        a  = exp_base + 32'(i) * 32'd4;
        d  = wr ? exp_seed + 32'(i) : 32'd0;
        return {(wr ? 3'd1 : 3'd0), 8'(i), a, 2'b00, d};
    endfunction

    initial begin
        mem_if.memreq_rdy  = 1'b0;
        mem_if.memresp_val = 1'b0;
        mem_if.memresp_msg = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0 || (limit_reads && reads_acc >= 2))
                mem_if.memreq_rdy = 1'b0;
            else if (rand_rdy)
                mem_if.memreq_rdy = ($urandom_range(0, 3) != 0);
            else
                mem_if.memreq_rdy = 1'b1;
            if (resp_q.size() > 0 && resp_q[0].rdy_cyc <= cyc && !(hold_reads && resp_q[0].is_read)) begin
                mem_if.memresp_val = 1'b1;
                mem_if.memresp_msg = resp_q[0].msg;
            end else begin
                mem_if.memresp_val = 1'b0;
                mem_if.memresp_msg = '0;
            end
            #4;
            if (done_next) begin
                chk("done_latency", done, 1);
                done_next = 0;
            end
            if (mem_if.memreq_val) begin
                val_cycles++;
                if (stall_cnt > 0) begin
                    if (stall_have) chk("stall_msg", mem_if.memreq_msg, stall_msg);
                    else begin
                        stall_msg  = mem_if.memreq_msg;
                        stall_have = 1;
                    end
                    stall_cnt--;
                end
            end
            if (mem_if.memreq_val && mem_if.memreq_rdy) begin
                m = mem_if.memreq_msg;
                if (req_cnt < 2 * exp_n) chk($sformatf("req%0d", req_cnt), m, exp_req(req_cnt));
                else chk("extra_req", req_cnt, 2 * exp_n);
                req_cnt++;
                mon_out++;
                if (mon_out > mon_max) mon_max = mon_out;
                r_type = m[76:74];
                r_op   = m[73:66];
                r_addr = m[65:34];
                r_data = m[31:0];
                if (r_type == 3'd1) begin
                    mem_arr[r_addr] = r_data;
                    rsp.msg     = {3'd1, r_op, 4'b0000, 32'd0};
                    rsp.is_read = 0;
                end else begin
                    rd = mem_arr.exists(r_addr) ? mem_arr[r_addr] : 32'd0;
                    if (corrupt_en && r_addr == corrupt_addr) rd = rd ^ 32'h1;
                    rsp.msg     = {3'd0, r_op, 4'b0000, rd};
                    rsp.is_read = 1;
                    reads_acc++;
                end
                rsp.rdy_cyc = cyc + 1 + ((max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0);
                resp_q.push_back(rsp);
            end
            if (mem_if.memresp_val && mem_if.memresp_rdy) begin
                void'(resp_q.pop_front());
                resp_cnt++;
                mon_out--;
                if (lat_chk && resp_cnt == 2 * exp_n) begin
                    chk("done_before_last", done, 0);
                    done_next = 1;
                end
            end
            cyc++;
        end
    end

    task automatic start(input logic [31:0] b, input int n, input logic [31:0] s);
        exp_base = b; exp_n = n; exp_seed = s;
        req_cnt = 0; resp_cnt = 0; mon_out = 0; mon_max = 0; val_cycles = 0; reads_acc = 0;
        @(negedge clk);
        base_addr = b; num_words = 16'(n); seed = s; go = 1'b1;
        @(negedge clk);
        go = 1'b0; base_addr = $urandom(); seed = $urandom(); num_words = 16'($urandom());
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    logic [31:0] b2, s2;
    int          w;

    initial begin
        reset = 1'b1; go = 1'b0; base_addr = '0; num_words = '0; seed = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_val", mem_if.memreq_val, 0);
        chk("rst_resp_rdy", mem_if.memresp_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {error, err_count}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("resp_rdy_idle", mem_if.memresp_rdy, 1);

        // Directed: zero-delay memory, 8 words from 0x1000, seed 0xA0.
        lat_chk = 1;
        start(32'h1000, 8, 32'hA0);
        chk("t1_busy", busy, 1);
        wait_done("t1", 500);
        chk("t1_reqs", req_cnt, 16);
        chk("t1_err", {error, err_count}, 0);
        chk("t1_word7", mem_arr[32'h101C], 32'hA7);

        // Random delays and ready, 64 words.
        max_dly = 10; rand_rdy = 1;
        b2 = $urandom(); b2[1:0] = 2'b00; s2 = $urandom();
        start(b2, 64, s2);
        wait_done("t2", 8000);
        chk("t2_reqs", req_cnt, 128);
        chk("t2_resps", resp_cnt, 128);
        chk("t2_err", {error, err_count}, 0);
        chk("t2_max_out_le4", (mon_max <= MAXO), 1);
        lat_chk = 0;

        // Corrupted read of word 3; address and data both wrap.
        corrupt_en = 1; corrupt_addr = 32'hFFFF_FFF0 + 32'd12;
        start(32'hFFFF_FFF0, 16, 32'hFFFF_FFFA);
        wait_done("t3", 3000);
        chk("t3_err_count", err_count, 1);
        chk("t3_error", error, 1);
        corrupt_en = 0;

        // Zero words: done straight away, no requests, error cleared.
        start($urandom(), 0, $urandom());
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_err_clr", {error, err_count}, 0);
        repeat (3) @(negedge clk);
        chk("t4_no_val", val_cycles, 0);

        // Stalled request must hold; go while busy is ignored.
        max_dly = 3; rand_rdy = 0; stall_cnt = 5; stall_have = 0;
        b2 = $urandom(); b2[1:0] = 2'b00; s2 = $urandom();
        start(b2, 12, s2);
        repeat (8) @(negedge clk);
        chk("t5_busy_mid", busy, 1);
        @(negedge clk);
        base_addr = 32'h0000_0040; seed = 32'h5555_0000; num_words = 16'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done("t5", 2000);
        chk("t5_reqs", req_cnt, 24);
        chk("t5_err", {error, err_count}, 0);

        // Reset during READ with two reads held in flight.
        max_dly = 0; hold_reads = 1; limit_reads = 1;
        start(32'h2000, 8, 32'h77);
        w = 0;
        while (reads_acc < 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("t6_reads_issued", reads_acc, 2);
        repeat (2) @(negedge clk);
        chk("t6_inflight", mon_out, 2);
        chk("t6_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_val", mem_if.memreq_val, 0);
        chk("t6_rst_msg", mem_if.memreq_msg, 0);
        chk("t6_rst_resp_rdy", mem_if.memresp_rdy, 0);
        chk("t6_rst_state", {busy, done, error, err_count}, 0);
        @(negedge clk);
        reset = 1'b1; hold_reads = 0; limit_reads = 0;
        w = 0;
        while (resp_q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("t6_late_err", err_count, 2);
        chk("t6_error", error, 1);
        chk("t6_idle", {busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_test_mem_initiator.md
# sm_test_mem_initiator

Self-checking memory traffic initiator: the requester end of the single-port test-memory request/response protocol. On `go` it writes a seeded data pattern to a contiguous word range, drains all write responses, reads the range back, and checks every read response. It limits the number of outstanding requests and reports `done`, `error` and an error count. It sits in unit and integration benches opposite the random-delay test memory, or in front of any cache or memory under test.

## Interface
- `p_opaque_nbits`, 8: width of the opaque field in request and response messages.
- `p_addr_nbits`, 32: width of the address field.
- `p_data_nbits`, 32: width of the data field, a multiple of 8; word stride is `p_data_nbits/8` bytes.
- `p_max_outstanding`, 4: maximum number of in-flight requests; must be in 1..2^`p_opaque_nbits`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  start pulse; sampled only in IDLE or DONE.
- `base_addr`  in  a  byte address of word 0; sampled on an accepted `go`.
- `num_words`  in  16  number of words to write and then read; sampled on `go`.
- `seed`  in  d  pattern seed; data for word i is `seed + i`, mod 2^d. Sampled on `go`.
- `memreq_val`/`memreq_rdy`/`memreq_msg`  out/in/out  1/1/c_req_nbits  request port.
- `memresp_val`/`memresp_rdy`/`memresp_msg`  in/out/in  1/1/c_resp_nbits  response port.
- `busy`  out  1  high in WRITE, WDRAIN, READ and RDRAIN.
- `done`  out  1  high in DONE.
- `error`  out  1  sticky; high when `err_count` is nonzero.
- `err_count`  out  16  number of mismatches; saturates at 0xFFFF.

## Operation
- Request fields, MSB first: type[2:0] (0 = read, 1 = write), opaque[o], addr[a], len[2] (always 0, meaning a full word), data[d]. The data field is 0 on reads.
- Response fields, MSB first: type[2:0], opaque[o], test[2] (ignored), len[2], data[d].
- States:
  - IDLE: on `go`, capture the inputs and clear `err_count`. Go to DONE if `num_words` is 0, otherwise go to WRITE.
  - WRITE: issue writes for i = 0..`num_words`-1 with addr = base + i·(d/8), opaque = i[o-1:0], data = seed + i. After the last write handshake, go to WDRAIN.
  - WDRAIN: when the outstanding count is 0, go to READ.
  - READ: issue reads for i = 0..`num_words`-1 using the same addressing. After the last read handshake, go to RDRAIN.
  - RDRAIN: when the outstanding count is 0, go to DONE.
  - DONE: on `go`, restart exactly as from IDLE.
- `memreq_val` is asserted when the state is WRITE or READ and the outstanding count is below `p_max_outstanding`.
- Outstanding count: +1 on a request handshake, −1 on a response handshake, unchanged when both happen in the same cycle.
- Checking: responses arrive in order. A response counter j counts responses per phase. A mismatch is counted when any of the following differ from expectation: type, opaque vs j[o-1:0], len vs 0, or (reads only) data vs seed + j.
- A response arriving in IDLE or DONE is accepted and counted as one error.
- A response while the outstanding count is 0 is counted as one error and leaves the count at 0.
- `go` is ignored while `busy` is high.

## Timing
- `reset` asserted forces IDLE, clears all counters, and drives every output to 0, including `memresp_rdy` and `memreq_val`.
- A reset mid-operation abandons all in-flight requests. Responses that arrive after reset are counted as errors.
- `memreq_val` first rises in the cycle after `go`. Once asserted, `memreq_val` and `memreq_msg` are held stable until `memreq_rdy` is high.
- Back-to-back requests are allowed: one per cycle while the outstanding limit permits.
- `memresp_rdy` is 1 in every state except while `reset` is asserted.
- `done` rises in the cycle after the last read response handshake, or in the cycle after `go` when `num_words` is 0.
- Address and data arithmetic wraps modulo 2^a and 2^d respectively.

## Structure
- Message field widths, `c_req_nbits`/`c_resp_nbits` macros and type encodings come from the shared memory-message header; no local redefinition.
- One natural sub-module: reuse the existing memory request and response message trace modules for the line trace, in the form `req()resp`.
- The remaining logic is one FSM, three counters (issue index, response index, outstanding) and the error counter, all inline.

## Test plan
- Paired with the zero-delay test memory; base 0x1000, 8 words, seed 0xA0: 8 writes, then 8 reads; `done` high, `err_count` 0; read data 0xA0..0xA7.
- Random delay 10, 64 words, `p_max_outstanding` 4: passes with `err_count` 0. A monitor confirms the outstanding count never exceeds 4.
- Memory model corrupts read data of word 3: `err_count` 1, `error` 1, `done` still reached.
- `num_words` 0: no `memreq_val`, `done` high one cycle after `go`.
- `memreq_rdy` held 0 for 5 cycles: `memreq_msg` stable throughout. `go` pulsed while busy has no effect.
- Reset asserted during READ with 2 requests outstanding: all outputs 0, state IDLE. The 2 late responses give `err_count` 2.
